// File: rtl/rv_decode_skid_stage.sv
// RV32/RV64 base-ISA decode stage: combinational decode into a registered
// main entry plus one skid entry, valid/ready on both sides.
`default_nettype none
`timescale 1ns/1ps

module rv_decode_skid_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_fmt,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [6:0] funct7; logic [4:0] rs2; logic [4:0] rs1;
    logic [2:0] funct3; logic [4:0] rd;  logic [6:0] opcode;
  } r_t;
  typedef struct packed {
    logic [11:0] imm; logic [4:0] rs1; logic [2:0] funct3;
    logic [4:0]  rd;  logic [6:0] opcode;
  } i_t;
  typedef struct packed {
    logic [6:0] imm_hi; logic [4:0] rs2; logic [4:0] rs1;
    logic [2:0] funct3; logic [4:0] imm_lo; logic [6:0] opcode;
  } s_t;
  typedef struct packed {
    logic       imm12;  logic [5:0] imm10_5; logic [4:0] rs2; logic [4:0] rs1;
    logic [2:0] funct3; logic [3:0] imm4_1;  logic imm11; logic [6:0] opcode;
  } b_t;
  typedef struct packed {
    logic [19:0] imm; logic [4:0] rd; logic [6:0] opcode;
  } u_t;
  typedef struct packed {
    logic       imm20; logic [9:0] imm10_1; logic imm11; logic [7:0] imm19_12;
    logic [4:0] rd;    logic [6:0] opcode;
  } j_t;
  typedef union packed {
    r_t r; i_t i; s_t s; b_t b; u_t u; j_t j; logic [31:0] raw;
  } insn_u;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } rec_t;

  insn_u       insn;
  rec_t        dec;
  logic [31:0] imm32;

  // Every listed opcode ends in 2'b11, so compressed encodings fall to default.
  always_comb begin
    insn       = in_insn;
    dec        = '0;
    imm32      = '0;
    dec.opcode = insn.r.opcode;
    case (insn.r.opcode)
      7'b0110011:                         dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:             dec.fmt = FMT_I;
      7'b0100011:                         dec.fmt = FMT_S;
      7'b1100011:                         dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:             dec.fmt = FMT_U;
      7'b1101111:                         dec.fmt = FMT_J;
      7'b0111011:                         dec.fmt = IS64 ? FMT_R : FMT_ILL;
      7'b0011011:                         dec.fmt = IS64 ? FMT_I : FMT_ILL;
      default:                            dec.fmt = FMT_ILL;
    endcase
    case (dec.fmt)
      FMT_R: begin
        dec.rd = insn.r.rd; dec.rs1 = insn.r.rs1; dec.rs2 = insn.r.rs2;
        dec.funct3 = insn.r.funct3; dec.funct7 = insn.r.funct7;
      end
      FMT_I: begin
        dec.rd = insn.i.rd; dec.rs1 = insn.i.rs1; dec.funct3 = insn.i.funct3;
        imm32 = {{20{insn.i.imm[11]}}, insn.i.imm};
      end
      FMT_S: begin
        dec.rs1 = insn.s.rs1; dec.rs2 = insn.s.rs2; dec.funct3 = insn.s.funct3;
        imm32 = {{20{insn.s.imm_hi[6]}}, insn.s.imm_hi, insn.s.imm_lo};
      end
      FMT_B: begin
        dec.rs1 = insn.b.rs1; dec.rs2 = insn.b.rs2; dec.funct3 = insn.b.funct3;
        imm32 = {{19{insn.b.imm12}}, insn.b.imm12, insn.b.imm11,
                 insn.b.imm10_5, insn.b.imm4_1, 1'b0};
      end
      FMT_U: begin
        dec.rd = insn.u.rd;
        imm32  = {insn.u.imm, 12'b0};
      end
      FMT_J: begin
        dec.rd = insn.j.rd;
        imm32  = {{11{insn.j.imm20}}, insn.j.imm20, insn.j.imm19_12,
                  insn.j.imm11, insn.j.imm10_1, 1'b0};
      end
      default: ;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  rec_t             main_q, main_d, skid_q, skid_d;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, emit;

  // The skid entry only fills while main is stalled, so it drains into main first.
  always_comb begin
    accept   = in_valid && in_ready_q;
    emit     = main_v_q && out_ready;
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;
    if (!main_v_q || emit) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = dec;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
    in_ready_d = !skid_v_d;
    if (accept && dec.fmt == FMT_ILL && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_v_q;
  assign out_fmt     = main_q.fmt;
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_imm     = main_q.imm;
  assign illegal_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_decode_skid_stage.sv
// Bench: two instances (XLEN=32/CNT_W=2 and XLEN=64/CNT_W=4) share stimulus;
// a scoreboard of model-decoded records is checked by an independent monitor.
`default_nettype none
`timescale 1ns/1ps

module tb_rv_decode_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_insn = '0;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [2:0]  a_fmt, b_fmt, a_f3, b_f3;
  logic [6:0]  a_opc, b_opc, a_f7, b_f7;
  logic [4:0]  a_rd, b_rd, a_rs1, b_rs1, a_rs2, b_rs2;
  logic [31:0] a_imm;
  logic [63:0] b_imm;
  logic [1:0]  a_cnt;
  logic [3:0]  b_cnt;

  rv_decode_skid_stage #(.XLEN(32), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_insn(in_insn), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_fmt(a_fmt), .out_opcode(a_opc), .out_rd(a_rd), .out_rs1(a_rs1),
    .out_rs2(a_rs2), .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm),
    .illegal_cnt(a_cnt));

  rv_decode_skid_stage #(.XLEN(64), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_insn(in_insn), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_fmt(b_fmt), .out_opcode(b_opc), .out_rd(b_rd), .out_rs1(b_rs1),
    .out_rs2(b_rs2), .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm),
    .illegal_cnt(b_cnt));

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] stim_q[$];
  int          ill_a = 0, ill_b = 0;
  int          nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference decode written from the ISA rules using signed arithmetic.
  function automatic exp_t model(input logic [31:0] w, input bit x64);
    exp_t   e;
    int     f;
    int     sw;
    longint s;
    e  = '0;
    sw = w;
    s  = sw;
    if (w[1:0] != 2'b11) f = 7;
    else case (w[6:0])
      7'h33:                             f = 0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = 1;
      7'h23:                             f = 2;
      7'h63:                             f = 3;
      7'h37, 7'h17:                      f = 4;
      7'h6F:                             f = 5;
      7'h3B:                             f = x64 ? 0 : 7;
      7'h1B:                             f = x64 ? 1 : 7;
      default:                           f = 7;
    endcase
    e.fmt = 3'(f);
    e.opc = w[6:0];
    if (f == 0 || f == 1 || f == 4 || f == 5) e.rd = w[11:7];
    if (f <= 3) begin
      e.rs1 = w[19:15];
      e.f3  = w[14:12];
    end
    if (f == 0 || f == 2 || f == 3) e.rs2 = w[24:20];
    if (f == 0) e.f7 = w[31:25];
    case (f)
      1: e.imm = s >>> 20;
      2: e.imm = ((s >>> 25) << 5) | longint'(w[11:7]);
      3: e.imm = ((s >>> 31) << 12) | (longint'(w[7]) << 11)
               | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      4: e.imm = s & 64'hFFFF_FFFF_FFFF_F000;
      5: e.imm = ((s >>> 31) << 20) | (longint'(w[19:12]) << 12)
               | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  // Monitor: occupancy-based handshake expectations plus head-of-queue compare.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ctrl_valid_ready", {a_out_valid, a_in_ready, b_out_valid, b_in_ready},
          {sbq.size() > 0, sbq.size() < 2, sbq.size() > 0, sbq.size() < 2});
      chk("cnt_a", a_cnt, (ill_a > 3) ? 3 : ill_a);
      chk("cnt_b", b_cnt, (ill_b > 15) ? 15 : ill_b);
      if (a_out_valid && sbq.size() > 0) begin
        chk("rec_a", {a_fmt, a_opc, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm},
            {sbq[0].a.fmt, sbq[0].a.opc, sbq[0].a.rd, sbq[0].a.rs1, sbq[0].a.rs2,
             sbq[0].a.f3, sbq[0].a.f7, sbq[0].a.imm[31:0]});
        chk("rec_b", {b_fmt, b_opc, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_imm}, sbq[0].b);
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  // One clock: decide acceptance mid-cycle, record it at the edge it happens on.
  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && a_in_ready && rst_n;
    @(posedge clk);
    if (acc) begin
      sbq.push_back('{a: model(in_insn, 1'b0), b: model(in_insn, 1'b1)});
      if (model(in_insn, 1'b0).fmt == 3'd7) ill_a++;
      if (model(in_insn, 1'b1).fmt == 3'd7) ill_b++;
    end
    #1;
  endtask

  // mode 0: sink always ready; 1: sink stalled 6 cycles then ready; 2: random.
  task automatic run(input int ncyc, input int mode);
    bit acc;
    bit hold;
    int c;
    hold = 1'b0;
    for (c = 0; c < ncyc && stim_q.size() > 0; c++) begin
      if (!hold) in_valid = (mode != 2) || ($urandom_range(0, 3) != 0);
      in_insn   = in_valid ? stim_q[0] : $urandom;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c >= 6) : ($urandom_range(0, 2) != 0);
      step(acc);
      if (acc) void'(stim_q.pop_front());
      hold = in_valid && !acc;
    end
    in_valid = 1'b0;
    if (stim_q.size() > 0) begin
      chk("stim_timeout", stim_q.size(), 0);
      stim_q.delete();
    end
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) step(acc);
    if (sbq.size() > 0) begin
      chk("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    sbq.delete();
    ill_a = 0;
    ill_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {a_out_valid, a_in_ready, a_cnt, b_out_valid, b_in_ready, b_cnt},
        {1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'd0});
    chk("reset_data", {a_fmt, a_opc, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm, b_imm}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops[13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                          7'h63, 7'h37, 7'h17, 7'h6F, 7'h3B, 7'h1B};

  initial begin
    bit          acc;
    logic [31:0] w;

    do_reset();

    // Single-word latency and U-format decode.
    stim_q.push_back(32'h0AA01EB7);
    run(10, 0);
    @(negedge clk);
    chk("lui_direct", {a_out_valid, a_fmt, a_opc, a_rd, a_imm},
        {1'b1, 3'd4, 7'h37, 5'd29, 32'h0AA01000});
    @(posedge clk);
    #1;

    stim_q.push_back(32'hFFF00093);
    run(10, 0);
    @(negedge clk);
    chk("addi_direct", {a_fmt, a_rd, a_rs1, a_imm, b_imm},
        {3'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF});
    @(posedge clk);
    #1;

    stim_q.push_back(32'hFE000EE3);
    stim_q.push_back(32'h0020A023);
    run(10, 0);
    drain();

    // Back-pressure: four words with the sink stalled, then released.
    for (int i = 0; i < 4; i++) stim_q.push_back(32'h00100013 + (i << 7));
    run(40, 1);
    drain();

    // Illegal encodings; narrow counter saturates at 3.
    do_reset();
    stim_q = '{32'h0000003B, 32'h00000000, 32'hFFFFFFFF, 32'h0000007F, 32'h0000003B};
    run(20, 0);
    drain();
    chk("cnt_sat_a", a_cnt, 2'd3);
    chk("cnt_b_rv64", b_cnt, 4'd3);

    // Asynchronous reset with both entries occupied.
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_insn = 32'h00000000;
    step(acc);
    in_insn = 32'h0020A023;
    step(acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    sbq.delete();
    ill_a = 0;
    ill_b = 0;
    #1;
    chk("async_reset", {a_out_valid, a_in_ready, a_cnt, b_out_valid, b_in_ready, b_cnt, a_imm},
        {1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 4'd0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(acc);

    // Randomized traffic, mostly valid opcodes with random fields.
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 12)];
      stim_q.push_back(w);
    end
    run(4000, 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
